// File: rtl/mdu_pkg.sv
// Shared types and sizing for the multiply/divide unit's iterative divider.
package mdu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/mdu_divider_if.sv
// Execute-stage <-> divider handshake and operand/result bundle.
interface mdu_divider_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             sign_i;
  logic             annul_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             div_zero_o;

  modport master (
    output start_i, sign_i, annul_i, opa_i, opb_i,
    input  busy_o, ready_o, quot_o, rem_o, div_zero_o
  );

  modport slave (
    input  start_i, sign_i, annul_i, opa_i, opb_i,
    output busy_o, ready_o, quot_o, rem_o, div_zero_o
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift, trial subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   prem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    shifted = {prem_i, quo_i[WIDTH-1]};
    diff    = shifted[WIDTH:0] - {1'b0, div_i};
    fits    = shifted >= {2'b00, div_i};
    prem_o  = fits ? diff : shifted[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative signed/unsigned divider producing quotient (LO) and remainder (HI),
// with pipeline stall, annul and divide-by-zero reporting.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  mdu_divider_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH / BITS_PER_CYCLE);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             negq_q;
  logic             negr_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             busy_q;
  logic             ready_q;

  logic [WIDTH-1:0] opa_abs;
  logic [WIDTH-1:0] opb_abs;
  logic [WIDTH:0]   prem_fin;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_d;

  // Chain of restoring steps; each stage feeds the next within one cycle.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [WIDTH:0]   prem_in;
    logic [WIDTH-1:0] quo_in;
    logic [WIDTH:0]   prem_out;
    logic [WIDTH-1:0] quo_out;

    if (g == 0) begin : g_first
      assign prem_in = prem_q;
      assign quo_in  = quo_q;
    end else begin : g_next
      assign prem_in = g_step[g-1].prem_out;
      assign quo_in  = g_step[g-1].quo_out;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
      .prem_i (prem_in),
      .quo_i  (quo_in),
      .div_i  (div_q),
      .prem_o (prem_out),
      .quo_o  (quo_out)
    );
  end

  assign prem_fin = g_step[BITS_PER_CYCLE-1].prem_out;
  assign quo_fin  = g_step[BITS_PER_CYCLE-1].quo_out;

  always_comb begin
    opa_abs = (bus.sign_i && bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
    opb_abs = (bus.sign_i && bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;
    quot_d  = negq_q ? -quo_fin : quo_fin;
    rem_d   = negr_q ? -prem_fin[WIDTH-1:0] : prem_fin[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            quo_q  <= opa_abs;
            div_q  <= opb_abs;
            prem_q <= '0;
            negq_q <= bus.sign_i && (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
            negr_q <= bus.sign_i && bus.opa_i[WIDTH-1];
            busy_q <= 1'b1;
            // A zero divisor skips iteration and reports immediately.
            if (bus.opb_i == '0) begin
              state_q <= DIV_DONE;
              cnt_q   <= '0;
              quot_q  <= '1;
              rem_q   <= bus.opa_i;
              dz_q    <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state_q <= DIV_BUSY;
              cnt_q   <= STEPS;
            end
          end
        end
        DIV_BUSY: begin
          if (bus.annul_i) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            prem_q <= prem_fin;
            quo_q  <= quo_fin;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DIV_DONE;
              quot_q  <= quot_d;
              rem_q   <= rem_d;
              dz_q    <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.ready_o    = ready_q;
  assign bus.quot_o     = quot_q;
  assign bus.rem_o      = rem_q;
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed self-checking bench for mdu_divider at one and two bits per cycle.
module tb_mdu_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_divider_if #(.WIDTH(32)) d1 ();
  mdu_divider_if #(.WIDTH(32)) d2 ();

  mdu_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (d1.slave)
  );

  mdu_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (d2.slave)
  );

  function automatic logic rdy(input int sel);
    return (sel == 2) ? d2.ready_o : d1.ready_o;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 2) ? d2.busy_o : d1.busy_o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start stays high across exactly one rising edge.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    if (sel == 2) begin
      d2.opa_i = a; d2.opb_i = b; d2.sign_i = s; d2.start_i = 1'b1;
    end else begin
      d1.opa_i = a; d1.opb_i = b; d1.sign_i = s; d1.start_i = 1'b1;
    end
    @(negedge clk);
    d1.start_i = 1'b0;
    d2.start_i = 1'b0;
  endtask

  task automatic waitReady(input int sel, output int cyc);
    cyc = 1;
    while (!rdy(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runDiv(input int sel, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input int lat,
                        input logic [31:0] q, input logic [31:0] r, input logic dz);
    int cyc;
    @(negedge clk);
    applyStimulus(sel, a, b, s);
    checkOutput({tag, ".busy"}, 32'(bsy(sel)), 32'd1);
    waitReady(sel, cyc);
    checkOutput({tag, ".lat"}, 32'(cyc), 32'(lat));
    checkOutput({tag, ".quot"}, (sel == 2) ? d2.quot_o : d1.quot_o, q);
    checkOutput({tag, ".rem"}, (sel == 2) ? d2.rem_o : d1.rem_o, r);
    checkOutput({tag, ".dz"}, 32'((sel == 2) ? d2.div_zero_o : d1.div_zero_o), 32'(dz));
  endtask

  initial begin
    int cyc;
    int seen;
    d1.start_i = 1'b0; d1.sign_i = 1'b0; d1.annul_i = 1'b0; d1.opa_i = '0; d1.opb_i = '0;
    d2.start_i = 1'b0; d2.sign_i = 1'b0; d2.annul_i = 1'b0; d2.opa_i = '0; d2.opb_i = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst.busy", 32'(d1.busy_o), 32'd0);
    checkOutput("rst.ready", 32'(d1.ready_o), 32'd0);
    checkOutput("rst.quot", d1.quot_o, 32'd0);
    checkOutput("rst.rem", d1.rem_o, 32'd0);
    checkOutput("rst.dz", 32'(d1.div_zero_o), 32'd0);
    rst = 1'b1;

    runDiv(1, "u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    runDiv(1, "sneg100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 33, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    runDiv(1, "s100_neg7", 32'd100, 32'hFFFFFFF9, 1'b1, 33, 32'hFFFFFFF2, 32'd2, 1'b0);
    runDiv(1, "smin_neg1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 32'h80000000, 32'd0, 1'b0);
    runDiv(1, "umin_neg1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 33, 32'd0, 32'h80000000, 1'b0);
    runDiv(1, "u5_0", 32'd5, 32'd0, 1'b0, 1, 32'hFFFFFFFF, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("u5_0.busyfall", 32'(d1.busy_o), 32'd0);
    checkOutput("u5_0.pulse", 32'(d1.ready_o), 32'd0);
    runDiv(1, "u9_3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

    // Annul during the tenth busy cycle, then restart in the very next cycle.
    @(negedge clk);
    applyStimulus(1, 32'd1000, 32'd3, 1'b0);
    seen = 0;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (d1.ready_o) seen++;
    end
    d1.annul_i = 1'b1;
    @(negedge clk);
    d1.annul_i = 1'b0;
    checkOutput("annul.busy", 32'(d1.busy_o), 32'd0);
    checkOutput("annul.noready", 32'(seen + int'(d1.ready_o)), 32'd0);
    checkOutput("annul.quot", d1.quot_o, 32'd3);
    checkOutput("annul.rem", d1.rem_o, 32'd0);
    applyStimulus(1, 32'd50, 32'd5, 1'b0);
    checkOutput("restart.busy", 32'(d1.busy_o), 32'd1);
    waitReady(1, cyc);
    checkOutput("restart.lat", 32'(cyc), 32'd33);
    checkOutput("restart.quot", d1.quot_o, 32'd10);
    checkOutput("restart.rem", d1.rem_o, 32'd0);

    // Start together with annul in IDLE must be ignored.
    @(negedge clk);
    d1.opa_i = 32'd77; d1.opb_i = 32'd7; d1.start_i = 1'b1; d1.annul_i = 1'b1;
    @(negedge clk);
    d1.start_i = 1'b0; d1.annul_i = 1'b0;
    checkOutput("idleannul.busy", 32'(d1.busy_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d1.ready_o) seen++;
    end
    checkOutput("idleannul.noready", 32'(seen), 32'd0);
    checkOutput("idleannul.quot", d1.quot_o, 32'd10);

    runDiv(2, "r2_ffff_10", 32'hFFFFFFFF, 32'h10, 1'b0, 17, 32'h0FFFFFFF, 32'hF, 1'b0);

    // Reset in busy cycle 5 discards the divide.
    @(negedge clk);
    applyStimulus(2, 32'd1234, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst.busy", 32'(d2.busy_o), 32'd0);
    checkOutput("midrst.ready", 32'(d2.ready_o), 32'd0);
    checkOutput("midrst.quot", d2.quot_o, 32'd0);
    checkOutput("midrst.rem", d2.rem_o, 32'd0);
    checkOutput("midrst.dz", 32'(d2.div_zero_o), 32'd0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d2.ready_o) seen++;
    end
    checkOutput("midrst.noready", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
# mdu_divider

Parametrised iterative divider for the multiply/divide unit of the pipelined MIPS core. It accepts a start pulse from the execute stage with a signed/unsigned selector and produces quotient and remainder for the HI/LO registers. While busy it holds the pipeline stall, and it can be annulled mid-operation when the issuing instruction is flushed. It generalises the core's fixed 32-bit, 1-bit-per-cycle divide to configurable width and radix, and adds explicit divide-by-zero reporting.

## Interface
- WIDTH, 32: operand/result width; even, ≥4
- BITS_PER_CYCLE, 1: restoring steps per cycle; 1 or 2; WIDTH divisible by it
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  launch divide (sampled only in IDLE)
- sign_i  in  1  1 = signed, 0 = unsigned (sampled with start_i)
- annul_i  in  1  cancel in-flight divide
- opa_i  in  WIDTH  dividend
- opb_i  in  WIDTH  divisor
- busy_o  out  1  state ≠ IDLE; drives pipeline stall
- ready_o  out  1  result valid, single-cycle pulse
- quot_o  out  WIDTH  quotient (to LO)
- rem_o  out  WIDTH  remainder (to HI)
- div_zero_o  out  1  last result came from opb_i == 0

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, start_i=1, annul_i=0: latch |opa|, |opb| (magnitude only when sign_i=1), latch sign flags.
  - opb_i≠0: go to BUSY with counter N = WIDTH/BITS_PER_CYCLE.
  - opb_i=0: go to DONE with quot=all ones, rem=opa_i, div_zero=1.
- IDLE, start_i=1, annul_i=1: annul wins; stay IDLE; nothing is latched.
- BUSY: each cycle performs BITS_PER_CYCLE restoring steps on a partial remainder of WIDTH+1 bits and decrements the counter. On the last step, apply sign fix-up, register quot_o/rem_o, clear div_zero_o, and go to DONE.
- Sign fix-up: quotient negated when sign_i=1 and operand signs differ; remainder takes the dividend's sign. Negation is two's complement modulo 2^WIDTH, so most-negative / -1 yields quot=most-negative, rem=0, with no flag.
- BUSY, annul_i=1: go to IDLE next cycle. No ready_o. Outputs keep their previous values.
- DONE: ready_o=1 for exactly one cycle, then IDLE. annul_i in DONE has no effect.
- quot_o, rem_o and div_zero_o hold until the next result is registered.
- start_i in BUSY or DONE is ignored. The core must not issue while busy_o=1.
- Reset: state IDLE, counter 0, busy_o=0, ready_o=0, quot_o=0, rem_o=0, div_zero_o=0. Reset mid-divide discards the operation.

## Timing
- Start sampled at edge 0.
- Normal divide: busy_o high from cycle 1; ready_o in cycle N+1. Defaults give ready_o in cycle 33; BITS_PER_CYCLE=2 gives cycle 17.
- Divide by zero: ready_o in cycle 1.
- busy_o is high in DONE and falls in the cycle after ready_o.
- Annul sampled in cycle k of BUSY: busy_o low in cycle k+1, and a new start is accepted in cycle k+1.
- Back-to-back: the earliest next start is the cycle after ready_o.

## Structure
- Package mdu_pkg: enum div_state_t {DIV_IDLE, DIV_BUSY, DIV_DONE}, plus a localparam for the counter width, $clog2(WIDTH+1).
- Sub-module div_step: one combinational restoring step (trial subtract, select, shift in quotient bit). Instantiate it BITS_PER_CYCLE times in a chain.

## Test plan
- Unsigned 100/7, WIDTH=32, BITS_PER_CYCLE=1 -> ready_o in cycle 33, quot=14, rem=2, div_zero=0.
- Signed -100/7 -> quot=0xFFFFFFF2, rem=0xFFFFFFFE. Signed 100/-7 -> quot=0xFFFFFFF2, rem=2.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0. Unsigned same operands -> quot=0, rem=0x80000000.
- 5/0 -> ready_o in cycle 1, quot=0xFFFFFFFF, rem=5, div_zero=1. A following 9/3 clears the flag: quot=3, rem=0.
- Annul at BUSY cycle 10 -> busy_o low in cycle 11, no ready_o, outputs unchanged. Restart 50/5 in cycle 11 -> quot=10.
- BITS_PER_CYCLE=2, 0xFFFFFFFF/0x10 unsigned -> ready_o in cycle 17, quot=0x0FFFFFFF, rem=0xF. Reset (rst=0) at cycle 5 -> all outputs 0, and no ready_o follows.
